zeroriscy_multdiv_iter: RTL and testbench
=========================================

Name: zeroriscy_multdiv_iter

Overview:
- Iterative radix-2 multiply/divide unit in the EX stage, alongside the ALU.
- Executes RV32M operations selected by the shared MD_OP_* encodings (MULL, MULH, DIV, REM) on 32-bit operands from ID/EX operand muxes.
- One operation in flight; result returned to the EX writeback mux with a one-cycle ready pulse.
- Uses sign-magnitude conversion around an unsigned 32-iteration shift-add / restoring-subtract core.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER_CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en_i  in  1  start request; sampled only in IDLE.
- operator_i  in  2  MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM.
- signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed. MULH: 11=MULH, 01=MULHSU, 00=MULHU. DIV/REM: 11 signed, 00 unsigned.
- op_a_i  in  WIDTH  multiplicand / dividend.
- op_b_i  in  WIDTH  multiplier / divisor.
- kill_i  in  1  abort current operation (flush).
- result_o  out  WIDTH  registered result; stable from ready_o until next accepted en_i.
- ready_o  out  1  one-cycle pulse: result_o valid.
- busy_o  out  1  high while iterating (state COMP).

Behaviour:
- Reset: state IDLE; result_o=0, ready_o=0, busy_o=0; counter, accumulators and sign flags cleared. Reset mid-operation discards the operation, no ready_o pulse.
- States: IDLE, COMP, FINISH.
- IDLE + en_i + !kill_i: latch operator, |op_a|, |op_b| (magnitude only where the signed bit is set and the operand MSB=1), sign flags; counter=WIDTH-1.
  - Divide special cases resolved directly, state -> FINISH, ready_o in cycle N+1 (en_i in cycle N).
  - Otherwise -> COMP.
- COMP: one iteration per cycle, counter decrements.
  - MUL: 64-bit accumulator, add |a| when current multiplier bit set, shift right.
  - DIV: restoring step on 64-bit {rem,quot}.
  - At counter==0: sign fix applied, result_o written, state -> FINISH.
- FINISH: ready_o=1 for exactly one cycle, then -> IDLE.
- Latency: en_i in cycle N -> ready_o in cycle N+33 for all non-special ops.
- Sign fix, MUL: negate 64-bit product iff sign_a XOR sign_b (each gated by its signed bit). MULL returns bits[31:0], MULH returns bits[63:32].
- Sign fix, DIV: quotient negated iff signs differ; remainder takes the dividend's sign.
- Divide by zero (op_b=0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a_i. Special-case path.
- Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, signed): DIV -> 0x80000000, REM -> 0. Special-case path.
- en_i outside IDLE: ignored; no queueing.
- kill_i in any state: next state IDLE, ready_o not asserted, result_o unchanged.
- kill_i and en_i together in IDLE: kill wins, nothing starts.
- Operand inputs are don't-care after the en_i cycle.

Decomposition:
- Shared zeroriscy_defines package: MD_OP_* (existing); add typedef enum logic[1:0] md_state_e {MD_IDLE, MD_COMP, MD_FINISH} and MD_SIGNED_A/MD_SIGNED_B bit indices.
- Sub-module zeroriscy_md_absval: combinational WIDTH-bit conditional two's-complement negate.
  - Used for operand magnitude (x2).
  - Used for result sign fix; the 64-bit product fix uses two chained instances with a carry.

Test Plan:
- MULL signed, a=7, b=0xFFFFFFFD (-3), en_i at cycle 0 -> ready_o at cycle 33 only, result_o=0xFFFFFFEB; busy_o high cycles 1..32.
- MULH signed_mode=11, a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV signed, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with ready_o at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, ready_o at cycle 1.
- Kill: start DIV at cycle 0, kill_i at cycle 10 -> IDLE at cycle 11, no ready_o, result_o unchanged. New en_i at cycle 12 completes normally at cycle 45. en_i pulses during COMP are ignored.
- Async rst asserted mid-COMP, between clock edges -> outputs 0 immediately. After deassertion, an en_i-to-ready_o transaction completes with the correct result.

Source files
------------

// File: rtl/zeroriscy_defines.sv
// Shared EX-stage definitions: mult/div operator encodings, FSM states, sign-mode bits.
package zeroriscy_defines;

    localparam int unsigned MD_OP_W = 2;

    localparam logic [MD_OP_W-1:0] MD_OP_MULL = 2'b00;
    localparam logic [MD_OP_W-1:0] MD_OP_MULH = 2'b01;
    localparam logic [MD_OP_W-1:0] MD_OP_DIV  = 2'b10;
    localparam logic [MD_OP_W-1:0] MD_OP_REM  = 2'b11;

    // Bit positions inside signed_mode_i
    localparam int unsigned MD_SIGNED_A = 0;
    localparam int unsigned MD_SIGNED_B = 1;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_COMP,
        MD_FINISH
    } md_state_e;

endpackage

// File: rtl/zeroriscy_md_absval.sv
// Conditional two's-complement negate; carry in/out allow chaining into wider words.
module zeroriscy_md_absval #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0] inv_sum;

    // Invert-and-add; passes the value through untouched when not negating
    always_comb begin
        inv_sum = {1'b0, ~value} + {{WIDTH{1'b0}}, cin};
        if (negate) begin
            result = inv_sum[WIDTH-1:0];
            cout   = inv_sum[WIDTH];
        end else begin
            result = value;
            cout   = 1'b0;
        end
    end

endmodule

// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative radix-2 RV32M multiply/divide: sign-magnitude around a 32-step unsigned core.
module zeroriscy_multdiv_iter
    import zeroriscy_defines::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ITER_CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [MD_OP_W-1:0] operator_i,
    input  logic [1:0]         signed_mode_i,
    input  logic [WIDTH-1:0]   op_a_i,
    input  logic [WIDTH-1:0]   op_b_i,
    input  logic               kill_i,
    output logic [WIDTH-1:0]   result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    md_state_e             state_q, state_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [MD_OP_W-1:0]    op_q, op_d;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]      opnd_q, opnd_d;
    logic                  sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]      result_d;
    logic                  ready_d, busy_d;

    logic             in_sign_a, in_sign_b, in_is_div, in_div_zero, in_div_ovf;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             is_div_q, is_rem_q, neg_prod;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_step, div_step;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] fix_lo_in, fix_lo_out, fix_hi_out, fixed_result;
    logic             fix_lo_neg, fix_lo_cout;
    logic             cout_a, cout_b, cout_hi;
    logic             unused_carry;

    assign in_sign_a   = signed_mode_i[MD_SIGNED_A] & op_a_i[WIDTH-1];
    assign in_sign_b   = signed_mode_i[MD_SIGNED_B] & op_b_i[WIDTH-1];
    assign in_is_div   = operator_i[1];
    assign in_div_zero = (op_b_i == '0);
    assign in_div_ovf  = (signed_mode_i == 2'b11) && (op_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                         && (op_b_i == '1);

    // Operand magnitudes
    zeroriscy_md_absval #(.WIDTH(WIDTH)) u_abs_a (
        .value(op_a_i), .negate(in_sign_a), .cin(1'b1), .result(mag_a), .cout(cout_a)
    );
    zeroriscy_md_absval #(.WIDTH(WIDTH)) u_abs_b (
        .value(op_b_i), .negate(in_sign_b), .cin(1'b1), .result(mag_b), .cout(cout_b)
    );

    assign is_div_q = op_q[1];
    assign is_rem_q = (op_q == MD_OP_REM);
    assign neg_prod = sign_a_q ^ sign_b_q;

    // One shift-add (multiply) or restoring-subtract (divide) iteration
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opnd_q};
        mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[ACC_W-1:1]};
        div_ge   = acc_q[ACC_W-1:WIDTH-1] >= {1'b0, opnd_q};
        div_diff = WIDTH'(acc_q[ACC_W-1:WIDTH-1] - {1'b0, opnd_q});
        div_step = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[ACC_W-2:0], 1'b0};
        acc_step = is_div_q ? div_step : mul_step;
    end

    // Result sign fix: low word carries into high word for the 64-bit product
    assign fix_lo_in  = is_rem_q ? acc_step[ACC_W-1:WIDTH] : acc_step[WIDTH-1:0];
    assign fix_lo_neg = is_rem_q ? sign_a_q : neg_prod;

    zeroriscy_md_absval #(.WIDTH(WIDTH)) u_fix_lo (
        .value(fix_lo_in), .negate(fix_lo_neg), .cin(1'b1),
        .result(fix_lo_out), .cout(fix_lo_cout)
    );
    zeroriscy_md_absval #(.WIDTH(WIDTH)) u_fix_hi (
        .value(acc_step[ACC_W-1:WIDTH]), .negate(neg_prod), .cin(fix_lo_cout),
        .result(fix_hi_out), .cout(cout_hi)
    );

    assign fixed_result = (op_q == MD_OP_MULH) ? fix_hi_out : fix_lo_out;
    assign unused_carry = cout_a ^ cout_b ^ cout_hi;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_o;

        case (state_q)
            MD_IDLE: begin
                if (en_i && !kill_i) begin
                    op_d     = operator_i;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    cnt_d    = ITER_CNT_W'(WIDTH - 1);
                    if (in_is_div) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
                    if (in_is_div && in_div_zero) begin
                        result_d = (operator_i == MD_OP_DIV) ? '1 : op_a_i;
                        state_d  = MD_FINISH;
                    end else if (in_is_div && in_div_ovf) begin
                        result_d = (operator_i == MD_OP_DIV) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
                        state_d  = MD_FINISH;
                    end else begin
                        state_d = MD_COMP;
                    end
                end
            end
            MD_COMP: begin
                acc_d = acc_step;
                cnt_d = cnt_q - ITER_CNT_W'(1);
                if (cnt_q == '0) begin
                    result_d = fixed_result;
                    state_d  = MD_FINISH;
                end
            end
            MD_FINISH: state_d = MD_IDLE;
            default:   state_d = MD_IDLE;
        endcase

        // Flush aborts everything and keeps the previous result
        if (kill_i) begin
            state_d  = MD_IDLE;
            result_d = result_o;
        end

        ready_d = (state_d == MD_FINISH);
        busy_d  = (state_d == MD_COMP);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_o <= result_d;
            ready_o  <= ready_d;
            busy_o   <= busy_d;
        end
    end

endmodule

// File: tb/tb_zeroriscy_multdiv_iter.sv
// Self-checking bench: arithmetic/timeline model compared every cycle plus directed literals.
module tb_zeroriscy_multdiv_iter;
    import zeroriscy_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic [1:0]  operator_i;
    logic [1:0]  signed_mode_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Transaction model: start cycle, latency class, kill point, expected values
    bit          mdl_live     = 1'b0;
    bit          mdl_killed   = 1'b0;
    bit          mdl_special  = 1'b0;
    int          mdl_start    = 0;
    int          mdl_kill_cyc = 0;
    logic [31:0] mdl_pending  = '0;
    logic [31:0] mdl_held     = '0;

    int          cmp_lat;
    bit          cmp_done, cmp_rdy, cmp_busy;
    logic [31:0] cmp_res;

    zeroriscy_multdiv_iter dut (
        .clk(clk), .rst(rst), .en_i(en_i), .operator_i(operator_i),
        .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .kill_i(kill_i), .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [1:0] sm,
                                                 input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb;
        logic [31:0]        r;
        bit                 ovf;
        ea  = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        ovf = (sm == 2'b11) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MD_OP_MULL: r = p[31:0];
            MD_OP_MULH: r = p[63:32];
            MD_OP_DIV: begin
                if (b == 0)           r = 32'hFFFF_FFFF;
                else if (ovf)         r = 32'h8000_0000;
                else if (sm == 2'b11) r = 32'(sa / sb);
                else                  r = a / b;
            end
            default: begin
                if (b == 0)           r = a;
                else if (ovf)         r = 32'h0;
                else if (sm == 2'b11) r = 32'(sa % sb);
                else                  r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [1:0] sm,
                                      input logic [31:0] a, input logic [31:0] b);
        return op[1] && ((b == 0) ||
               ((sm == 2'b11) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle compare of all outputs against the model timeline
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_lat  = mdl_special ? 1 : 33;
            cmp_done = mdl_live && !mdl_killed && (cyc >= mdl_start + cmp_lat);
            cmp_rdy  = mdl_live && !mdl_killed && (cyc == mdl_start + cmp_lat);
            cmp_busy = mdl_live && !mdl_special && (cyc >= mdl_start + 1) &&
                       (cyc <= mdl_start + 32) && (!mdl_killed || cyc <= mdl_kill_cyc);
            cmp_res  = cmp_done ? mdl_pending : mdl_held;
            check("ready_o", 32'(ready_o), 32'(cmp_rdy));
            check("busy_o", 32'(busy_o), 32'(cmp_busy));
            check("result_o", result_o, cmp_res);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns one cycle later with en_i dropped
    task automatic start_op(input logic [1:0] op, input logic [1:0] sm,
                            input logic [31:0] a, input logic [31:0] b);
        if (mdl_live && !mdl_killed) mdl_held = mdl_pending;
        en_i          = 1'b1;
        operator_i    = op;
        signed_mode_i = sm;
        op_a_i        = a;
        op_b_i        = b;
        mdl_live      = 1'b1;
        mdl_killed    = 1'b0;
        mdl_start     = cyc;
        mdl_special   = is_special(op, sm, a, b);
        mdl_pending   = model_result(op, sm, a, b);
        @(posedge clk);
        #1;
        en_i          = 1'b0;
        operator_i    = 2'($urandom);
        signed_mode_i = 2'($urandom);
        op_a_i        = $urandom;
        op_b_i        = $urandom;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        start_op(op, sm, a, b);
        wait_until(mdl_start + (mdl_special ? 1 : 33));
        check({name, "_result"}, result_o, lit);
        check({name, "_ready"}, 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; kill_i = 1'b0;
        operator_i = '0; signed_mode_i = '0; op_a_i = '0; op_b_i = '0;
        #1;
        check("rst_result", result_o, 32'h0);
        check("rst_ready", 32'(ready_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);

        check("model_mull", model_result(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_mulhsu", model_result(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("model_div", model_result(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_rem", model_result(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("mull_s", MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

        // Kill a divide ten cycles in; then restart two cycles later
        start_op(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_until(mdl_start + 10);
        kill_i       = 1'b1;
        mdl_killed   = 1'b1;
        mdl_kill_cyc = cyc;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        check("kill_busy", 32'(busy_o), 32'h0);
        check("kill_result", result_o, 32'hFFFF_FFEB);
        wait_until(mdl_kill_cyc + 2);

        // en_i pulse during COMP must be ignored
        start_op(MD_OP_DIV, 2'b00, 32'd100, 32'd7);
        wait_until(mdl_start + 6);
        en_i = 1'b1; operator_i = MD_OP_MULL; signed_mode_i = 2'b00;
        op_a_i = 32'd3; op_b_i = 32'd5;
        @(posedge clk);
        #1;
        en_i = 1'b0;
        wait_until(mdl_start + 33);
        check("divu_after_kill_result", result_o, 32'd14);
        check("divu_after_kill_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;

        run_op("div_ovf", MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("div_s", MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_s", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_zero", MD_OP_DIV, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_zero", MD_OP_REM, 2'b00, 32'd5, 32'd0, 32'd5);

        // kill_i together with en_i in IDLE: nothing starts
        en_i = 1'b1; kill_i = 1'b1; operator_i = MD_OP_MULL; signed_mode_i = 2'b00;
        op_a_i = 32'd9; op_b_i = 32'd9;
        @(posedge clk);
        #1;
        en_i = 1'b0; kill_i = 1'b0;
        check("kill_en_busy", 32'(busy_o), 32'h0);
        check("kill_en_result", result_o, 32'd5);
        repeat (3) @(posedge clk);
        #1;

        run_op("mulh_s", MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu", MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu", MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Asynchronous reset between clock edges in the middle of COMP
        start_op(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD);
        wait_until(mdl_start + 10);
        #3;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("async_rst_result", result_o, 32'h0);
        check("async_rst_ready", 32'(ready_o), 32'h0);
        check("async_rst_busy", 32'(busy_o), 32'h0);
        mdl_live = 1'b0;
        mdl_held = 32'h0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("remu_after_rst", MD_OP_REM, 2'b00, 32'd100, 32'd7, 32'd2);
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
